// File: rtl/ctrl_pkg.sv
// Shared constants for the control path: default conditioner parameters and
// the 2-bit state encoding used by the downstream state machine.
package ctrl_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

  // Downstream state machine encoding, kept here so both sides agree.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_RESTART = 2'b11
  } ctrl_state_e;

endpackage : ctrl_pkg

// File: rtl/debounce_channel.sv
// One push-button channel: synchronizer chain, stability counter, debounced
// level and rising-edge (press) detection.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   btn_raw : raw asynchronous button, 1 = pressed
//   press_c : combinational one-cycle press flag (debounced 0->1)
module debounce_channel
  import ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   prev_q, prev_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  // Synchronizer shift, stability count and level acceptance.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    prev_d  = level_q;

    if (synced == level_q) begin
      // Any return to the accepted level restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Accepting the level also clears the count, so it never wraps.
      level_d = synced;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Press only on 0->1; release is ignored.
  assign press_c = level_q & ~prev_q;

endmodule : debounce_channel

// File: rtl/control_conditioner.sv
// Conditions two raw push buttons into control signals for the downstream
// state machine: a one-cycle restart pulse and a toggled pause level.
//   iClk        : system clock, rising edge
//   iRestart    : synchronous active-high reset
//   iBtnRestart : raw bouncing restart button, 1 = pressed
//   iBtnPause   : raw bouncing pause button, 1 = pressed
//   oRestart    : registered one-cycle restart pulse
//   oPause      : registered pause level, 1 = paused
module control_conditioner
  import ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic iClk,
  input  logic iRestart,
  input  logic iBtnRestart,
  input  logic iBtnPause,
  output logic oRestart,
  output logic oPause
);

  logic press_restart_c;
  logic press_pause_c;
  logic restart_q, restart_d;
  logic pause_q, pause_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_restart_ch (
    .clk     (iClk),
    .rst     (iRestart),
    .btn_raw (iBtnRestart),
    .press_c (press_restart_c)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_pause_ch (
    .clk     (iClk),
    .rst     (iRestart),
    .btn_raw (iBtnPause),
    .press_c (press_pause_c)
  );

  // Output registers.
  always_ff @(posedge iClk) begin
    if (iRestart) begin
      restart_q <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      restart_q <= restart_d;
      pause_q   <= pause_d;
    end
  end

  // Restart wins over pause: it clears the pause level and drops any
  // pause toggle flagged in the same cycle.
  always_comb begin
    restart_d = press_restart_c;
    pause_d   = pause_q;
    if (press_restart_c) begin
      pause_d = 1'b0;
    end else if (press_pause_c) begin
      pause_d = ~pause_q;
    end
  end

  assign oRestart = restart_q;
  assign oPause   = pause_q;

endmodule : control_conditioner

// File: doc/control_conditioner.md
CONTROL_CONDITIONER -- requirements
Module: control_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a button level change; legal range 2..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per raw button input; legal range 2..4.
REQ-003 SHALL have port iClk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port iRestart, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port iBtnRestart, input, 1 bit: raw, asynchronous, bouncing restart push button; 1 = pressed.
REQ-006 SHALL have port iBtnPause, input, 1 bit: raw, asynchronous, bouncing pause push button; 1 = pressed.
REQ-007 SHALL have port oRestart, output, 1 bit: one-cycle restart pulse driving the downstream state machine's iRestart.
REQ-008 SHALL have port oPause, output, 1 bit: pause level driving the downstream state machine's iPause; 1 = paused.

Function
REQ-009 Each raw button SHALL pass through a SYNC_STAGES-deep flop chain before any other logic uses it.
REQ-010 Each channel SHALL hold a debounced level and a counter sized to $clog2(DEBOUNCE_CYCLES)+1 bits.
- Synced value equals the debounced level: counter cleared to 0.
- Synced value differs and counter = DEBOUNCE_CYCLES-1: debounced level takes the synced value and the counter clears on that edge.
- Synced value differs otherwise: counter increments.
REQ-011 Any single-cycle return of the synced value to the debounced level SHALL clear the counter, so a glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
REQ-012 Each channel SHALL register its previous debounced level and flag a press when the debounced level goes 0->1; release (1->0) SHALL produce no event.
REQ-013 oRestart SHALL be registered and SHALL be 1 for exactly one cycle per restart press, on the edge after the press is flagged.
REQ-014 A pause press SHALL toggle oPause on the edge after the press is flagged; holding the button SHALL produce no further toggles.
REQ-015 Latency from the first rising edge that samples a clean new button level to the registered output change SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles; this is 7 cycles at the default parameters.
REQ-016 A restart press SHALL force oPause to 0 on the same edge that oRestart asserts.
REQ-017 Restart and pause presses flagged in the same cycle SHALL give oRestart = 1 and oPause = 0, and the pause toggle SHALL be discarded.
REQ-018 Button activity while oRestart is high SHALL be processed normally; no lockout window.
REQ-019 Counters SHALL never wrap: the counter saturates at DEBOUNCE_CYCLES-1 because the level update clears it.

Reset
REQ-020 With iRestart = 1 at a rising edge, all synchronizer flops, debounced levels, previous levels and counters SHALL clear to 0; oRestart SHALL be 0 and oPause SHALL be 0 after that edge.
REQ-021 iRestart asserted mid-debounce SHALL discard the partial count; a button still held after reset SHALL be treated as a new press and generate one event after the REQ-015 latency.
REQ-022 iRestart SHALL take priority over every other event in the same cycle.

Structure
REQ-023 Default values of DEBOUNCE_CYCLES and SYNC_STAGES SHALL live in the shared constants package ctrl_pkg, alongside the 2-bit state encoding used downstream.
REQ-024 Synchronizer, counter, debounced level and press detection SHALL be one sub-module, debounce_channel, instantiated twice.
REQ-025 control_conditioner top level SHALL hold only the oRestart register, the oPause toggle register and the priority logic.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 20-unit clock period)
REQ-026 Reset held 2 cycles with both buttons 1 -> oRestart = 0 and oPause = 0 during reset; oRestart pulses once 7 cycles after reset release.
REQ-027 Clean iBtnPause press held 20 cycles -> oPause goes 0->1 exactly 7 cycles after the first sampling edge; no further toggle; release gives no change.
REQ-028 iBtnPause bouncing 1,0,1,0 at 1-cycle intervals, then steady 1 -> a single toggle, 7 cycles after the steady level starts.
REQ-029 3-cycle glitch on iBtnRestart -> oRestart stays 0 throughout.
REQ-030 oPause = 1, then restart and pause presses flagged in the same cycle -> oRestart = 1 for one cycle and oPause = 0.
REQ-031 iRestart pulsed 1 cycle when a pause counter reads 2 -> no toggle from the partial count; held button yields one toggle 7 cycles after reset release.
